// File: rtl/edge_stream_sched.sv
// -----------------------------------------------------------------------------
// edge_stream_sched
//
// Shares one single-port synchronous adjacency RAM between host edge-list
// loading and graph-walker lookups. For each accepted walker request the
// node's header word {count, base} is read from address node_idx, then the
// node's successor indices are streamed one per cycle from base upwards
// (wrapping modulo 2^ADDR_WIDTH), each tagged with a descending
// remaining-count so the final edge carries count 1.
//
// Handshakes: every valid/ready pair transfers when both are high in the same
// cycle. Producers hold data stable while valid is high and ready is low;
// ready is never a precondition for asserting valid.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_node_idx          walker lookup request
//   edge_valid/edge_ready/edge_node_idx/edge_counter  successor stream
//   err_zero_edge                   one-cycle pulse: header count was zero
//   host_wr_valid/host_wr_ready/host_wr_addr/host_wr_data  host RAM load
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  RAM port, 1-cycle read latency
//   state_dbg_o                     current FSM state (IDLE/HDR_RD/HDR_LATCH/STREAM)
//
// Build option
//   EDGE_SCHED_RR_ARB_EN  defined: round-robin host/walker arbitration in IDLE.
//                         undefined: fixed host priority.
// -----------------------------------------------------------------------------
module edge_stream_sched #(
    parameter int NODE_IDX_WIDTH = 10,
    parameter int COUNTER_WIDTH  = 4,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [NODE_IDX_WIDTH-1:0] req_node_idx,
    output logic                      edge_valid,
    input  logic                      edge_ready,
    output logic [NODE_IDX_WIDTH-1:0] edge_node_idx,
    output logic [COUNTER_WIDTH-1:0]  edge_counter,
    output logic                      err_zero_edge,
    input  logic                      host_wr_valid,
    output logic                      host_wr_ready,
    input  logic [ADDR_WIDTH-1:0]     host_wr_addr,
    input  logic [DATA_WIDTH-1:0]     host_wr_data,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [1:0]                state_dbg_o
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] HDR_RD    = 2'd1;
    localparam logic [1:0] HDR_LATCH = 2'd2;
    localparam logic [1:0] STREAM    = 2'd3;

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                state_q, state_d;
    logic [NODE_IDX_WIDTH-1:0] node_q, node_d;
    logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d;
    logic [COUNTER_WIDTH-1:0]  issue_left_q, issue_left_d;
    logic [COUNTER_WIDTH-1:0]  out_left_q, out_left_d;
    logic                      edge_valid_q, edge_valid_d;
    logic [COUNTER_WIDTH-1:0]  edge_cnt_q, edge_cnt_d;
    logic [NODE_IDX_WIDTH-1:0] edge_idx_q, edge_idx_d;
    logic                      fresh_q, fresh_d;

    logic                      in_idle;
    logic                      host_win;
    logic                      host_grant;
    logic                      walk_grant;
    logic                      issue;
    logic [COUNTER_WIDTH-1:0]  hdr_cnt;
    logic [ADDR_WIDTH-1:0]     hdr_base;

    assign hdr_cnt  = mem_rdata[DATA_WIDTH-1 -: COUNTER_WIDTH];
    assign hdr_base = mem_rdata[ADDR_WIDTH-1:0];

    // Grants are gated by rst_n so that both ready outputs and the RAM port
    // drop the moment reset is asserted, even with requesters still valid.
    assign in_idle = (state_q == IDLE) && rst_n;

`ifdef EDGE_SCHED_RR_ARB_EN
    logic last_host_q, last_host_d;

    // Host wins unless the walker is also waiting and the host had the last grant.
    assign host_win = !req_valid || !last_host_q;

    always_comb begin
        last_host_d = last_host_q;
        if (host_grant) begin
            last_host_d = 1'b1;
        end else if (walk_grant) begin
            last_host_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_host_q <= 1'b0;
        end else begin
            last_host_q <= last_host_d;
        end
    end
`else
    assign host_win = 1'b1;
`endif

    assign host_grant = in_idle && host_wr_valid && host_win;
    assign walk_grant = in_idle && req_valid && !host_grant;

    // A read issued now lands in the output stage next cycle, so it may only
    // go out when that stage will be free by then.
    assign issue = (state_q == STREAM) && (issue_left_q != CNT_ZERO)
                   && (!edge_valid_q || edge_ready);

    always_comb begin
        state_d       = state_q;
        node_d        = node_q;
        ptr_d         = ptr_q;
        issue_left_d  = issue_left_q;
        out_left_d    = out_left_q;
        edge_valid_d  = edge_valid_q;
        edge_cnt_d    = edge_cnt_q;
        edge_idx_d    = edge_idx_q;
        fresh_d       = issue;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        err_zero_edge = 1'b0;

        case (state_q)
            IDLE: begin
                if (host_grant) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = host_wr_addr;
                    mem_wdata = host_wr_data;
                end else if (walk_grant) begin
                    node_d  = req_node_idx;
                    state_d = HDR_RD;
                end
            end
            HDR_RD: begin
                mem_en   = 1'b1;
                mem_addr = {{(ADDR_WIDTH-NODE_IDX_WIDTH){1'b0}}, node_q};
                state_d  = HDR_LATCH;
            end
            HDR_LATCH: begin
                if (hdr_cnt == CNT_ZERO) begin
                    err_zero_edge = 1'b1;
                    state_d       = IDLE;
                end else begin
                    issue_left_d = hdr_cnt;
                    out_left_d   = hdr_cnt;
                    ptr_d        = hdr_base;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                if (issue) begin
                    mem_en       = 1'b1;
                    mem_addr     = ptr_q;
                    ptr_d        = ptr_q + ADDR_ONE;
                    issue_left_d = issue_left_q - CNT_ONE;
                end
                if (edge_valid_q && edge_ready && (edge_cnt_q == CNT_ONE)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The counter is registered alongside the read so it appears with the
        // returned word; the index itself is captured from the RAM one cycle
        // later and held from then on.
        if (fresh_q) begin
            edge_idx_d = mem_rdata[NODE_IDX_WIDTH-1:0];
        end
        if (issue) begin
            edge_valid_d = 1'b1;
            edge_cnt_d   = out_left_q;
            out_left_d   = out_left_q - CNT_ONE;
        end else if (edge_valid_q && edge_ready) begin
            edge_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            node_q       <= '0;
            ptr_q        <= '0;
            issue_left_q <= '0;
            out_left_q   <= '0;
            edge_valid_q <= 1'b0;
            edge_cnt_q   <= '0;
            edge_idx_q   <= '0;
            fresh_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            node_q       <= node_d;
            ptr_q        <= ptr_d;
            issue_left_q <= issue_left_d;
            out_left_q   <= out_left_d;
            edge_valid_q <= edge_valid_d;
            edge_cnt_q   <= edge_cnt_d;
            edge_idx_q   <= edge_idx_d;
            fresh_q      <= fresh_d;
        end
    end

    assign req_ready     = walk_grant;
    assign host_wr_ready = host_grant;
    assign edge_valid    = edge_valid_q;
    assign edge_counter  = edge_cnt_q;
    // In the cycle the read returns, pass the RAM word straight through.
    assign edge_node_idx = fresh_q ? mem_rdata[NODE_IDX_WIDTH-1:0] : edge_idx_q;
    assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_edge_stream_sched.sv
`timescale 1ns/1ps
module tb_edge_stream_sched;

    localparam int NW = 10;
    localparam int CW = 4;
    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [NW-1:0] req_node_idx = '0;
    logic          edge_valid;
    logic          edge_ready = 1'b0;
    logic [NW-1:0] edge_node_idx;
    logic [CW-1:0] edge_counter;
    logic          err_zero_edge;
    logic          host_wr_valid = 1'b0;
    logic          host_wr_ready;
    logic [AW-1:0] host_wr_addr = '0;
    logic [DW-1:0] host_wr_data = '0;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    state_dbg;

    logic [DW-1:0]    ram    [0:4095];
    logic [DW-1:0]    shadow [0:4095];
    logic [NW+CW-1:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int w;

    edge_stream_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_node_idx  (req_node_idx),
        .edge_valid    (edge_valid),
        .edge_ready    (edge_ready),
        .edge_node_idx (edge_node_idx),
        .edge_counter  (edge_counter),
        .err_zero_edge (err_zero_edge),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .state_dbg_o   (state_dbg)
    );

    // ---------------- clock / cycle counter / RAM ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- comparison ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // A node's stream is its header count of words starting at base (mod 4096),
    // each reduced to its low index bits, tagged count, count-1, ..., 1.
    function automatic int model_push(input int node);
        logic [DW-1:0]    h;
        logic [AW-1:0]    a;
        logic [DW-1:0]    word;
        int               n;
        h = shadow[node];
        n = int'(h[15:12]);
        for (int i = 0; i < n; i++) begin
            a    = AW'(int'(h[11:0]) + i);
            word = shadow[a];
            exp_q.push_back({word[NW-1:0], CW'(n - i)});
        end
        return n;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic             stall_q = 1'b0;
    logic [NW+CW-1:0] stall_val = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("edge_hold", {edge_valid, edge_node_idx, edge_counter}, {1'b1, stall_val});
            if (edge_valid && edge_ready) begin
                if (exp_q.size() == 0) chk("edge_unexpected", exp_q.size(), 1);
                else                   chk("edge", {edge_node_idx, edge_counter}, exp_q.pop_front());
            end
            stall_q   = edge_valid && !edge_ready;
            stall_val = {edge_node_idx, edge_counter};
            if (host_wr_valid && host_wr_ready) shadow[host_wr_addr] = host_wr_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctrl"}, {req_ready, host_wr_ready, edge_valid, err_zero_edge, mem_en, mem_we}, 0);
        chk({tag, "_edge"}, {edge_node_idx, edge_counter}, 0);
        chk({tag, "_mem"},  {mem_addr, mem_wdata}, 0);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        host_wr_valid = 1'b1; host_wr_addr = a; host_wr_data = d;
        @(negedge clk);
        chk("host_ready", host_wr_ready, 1);
        chk("host_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, a, d});
    endtask

    task automatic host_idle();
        @(posedge clk); #1;
        host_wr_valid = 1'b0;
    endtask

    // Issue one walker request and follow it until the FSM is back in IDLE.
    // Cycle numbers are relative to the accept cycle T (k = 0).
    task automatic walk(input int node, input bit host_hold, input int bp_pct,
                        input logic [31:0] rdy_mask, input int exp_done, output int wait_cyc);
        int t0, k, first, done, err_k, err_n, n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_node_idx = NW'(node); host_wr_valid = host_hold;
        edge_ready = rdy_mask[0];
        wait_cyc = 0;
        @(negedge clk);
        while (!req_ready && wait_cyc < 16) begin
            @(posedge clk); #1;
            wait_cyc++;
            @(negedge clk);
        end
        chk("req_accept", req_ready, 1);
        t0 = cyc;
        n = model_push(node);
        first = -1; done = -1; err_k = -1; err_n = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            k = cyc - t0;
            if (bp_pct > 0)   edge_ready = ($urandom_range(99) >= bp_pct);
            else if (k < 32)  edge_ready = rdy_mask[k];
            else              edge_ready = 1'b1;
            @(negedge clk);
            if (err_zero_edge) begin
                err_n++;
                if (err_k < 0) err_k = k;
            end
            if (edge_valid && first < 0) first = k;
            if (state_dbg != 2'd0) begin
                chk("host_blocked", host_wr_ready, 0);
            end else begin
                done = k;
                break;
            end
        end
        if (n == 0) begin
            chk("zero_err_cycle", err_k, 2);
            chk("zero_err_pulses", err_n, 1);
            chk("zero_no_edge", first < 0, 1);
        end else begin
            chk("first_edge_cycle", first, 4);
            chk("no_err", err_n, 0);
        end
        if (exp_done >= 0) chk("done_cycle", done, exp_done);
        else               chk("completed", done > 0, 1);
        chk("all_edges_seen", exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // reset with both requesters active: nothing may leak out
        rst_n = 1'b0; host_wr_valid = 1'b1; host_wr_addr = 12'h005; host_wr_data = 16'hBEEF;
        req_valid = 1'b1; req_node_idx = 10'd5; edge_ready = 1'b1;
        #22;
        check_outputs_zero("reset");
        chk("reset_state", state_dbg, 0);
        host_wr_valid = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // back-to-back host load
        host_write(12'h005, 16'h3400);
        host_write(12'h400, 16'h0007);
        host_write(12'h401, 16'hFC09);
        host_write(12'h402, 16'h0002);
        host_write(12'h00C, 16'h0400);
        host_write(12'h014, 16'h2FFF);
        host_write(12'hFFF, 16'h0155);
        host_write(12'h000, 16'h02AA);
        host_idle();

        // node 5, consumer always ready: (7,3) (9,2) (2,1), idle again at T+7
        walk(5, 1'b0, 0, 32'hFFFF_FFFF, 7, w);
        chk("walk5_wait", w, 0);

        // consumer stalls at T+5 and T+6
        walk(5, 1'b0, 0, 32'hFFFF_FF9F, 9, w);

        // zero-edge header
        walk(12, 1'b0, 0, 32'hFFFF_FFFF, 3, w);

        // base 0xFFF wraps to 0x000
        walk(20, 1'b0, 0, 32'hFFFF_FFFF, 6, w);

        // host and walker contending
`ifdef EDGE_SCHED_RR_ARB_EN
        host_wr_addr = 12'h800; host_wr_data = 16'h1234;
        walk(5, 1'b1, 0, 32'hFFFF_FFFF, 7, w);
        chk("rr_walker_second", w, 1);
        chk("rr_host_after", host_wr_ready, 1);
        host_idle();
`else
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            host_wr_valid = 1'b1; host_wr_addr = AW'(12'h800 + i); host_wr_data = DW'(16'h1000 + i);
            req_valid = 1'b1; req_node_idx = 10'd5;
            @(negedge clk);
            chk("prio_host", host_wr_ready, 1);
            chk("prio_walker_starved", req_ready, 0);
        end
        walk(5, 1'b0, 0, 32'hFFFF_FFFF, 7, w);
        chk("walker_after_host_drop", w, 0);
`endif

        // reset in the middle of a stream
        @(posedge clk); #1;
        req_valid = 1'b1; req_node_idx = 10'd5; edge_ready = 1'b1;
        @(negedge clk);
        chk("mid_req_accept", req_ready, 1);
        w = model_push(5);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0; host_wr_valid = 1'b1; host_wr_addr = 12'h900;
        #1;
        check_outputs_zero("mid_reset");
        chk("mid_reset_left", exp_q.size(), 2);
        exp_q.delete();
        @(posedge clk); #1;
        host_wr_valid = 1'b0;
        rst_n = 1'b1;
        walk(5, 1'b0, 0, 32'hFFFF_FFFF, 7, w);

        // randomized nodes with random backpressure
        for (int r = 0; r < 6; r++) begin
            int            node, cnt;
            logic [AW-1:0] base;
            node = $urandom_range(100, 1023);
            cnt  = $urandom_range(0, 15);
            base = AW'($urandom_range(12'h400, 12'hFFF));
            host_write(AW'(node), {CW'(cnt), base});
            for (int i = 0; i < cnt; i++) host_write(AW'(int'(base) + i), DW'($urandom));
            host_idle();
            walk(node, 1'b0, 30, 32'hFFFF_FFFF, -1, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
